// File: rtl/zpu_bridge_pkg.sv
// Shared types and constants for the zpu_core memory bridge: FSM encoding,
// I/O page word offsets and the default ID register value.
package zpu_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAM_RD,
    RAM_WR,
    IO,
    DONE
  } state_e;

  localparam logic [3:0]  IO_LED   = 4'd0;
  localparam logic [3:0]  IO_ID    = 4'd1;
  localparam logic [3:0]  IO_TIMER = 4'd2;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h5A50_0001;

endpackage

// File: rtl/zpu_mem_bridge_if.sv
// CPU memory port plus block-RAM port of the bridge. The slave modport is the
// bridge's view; the master modport is the CPU/RAM side.
interface zpu_mem_bridge_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int RAM_AW     = 10
);
  logic                  cpu_read;
  logic                  cpu_write;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [31:0]           cpu_wdata;
  logic [31:0]           cpu_rdata;
  logic                  cpu_done;
  logic [RAM_AW-1:0]     ram_addr;
  logic                  ram_we;
  logic [31:0]           ram_din;
  logic [31:0]           ram_dout;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, ram_dout,
    output cpu_rdata, cpu_done, ram_addr, ram_we, ram_din
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, ram_dout,
    input  cpu_rdata, cpu_done, ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/zpu_bridge_io.sv
// I/O register page: LED register, constant ID and, when ZPU_BRIDGE_TIMER_EN
// is defined, a loadable free-running 32-bit cycle counter.
module zpu_bridge_io
  import zpu_bridge_pkg::*;
#(
  parameter int          LED_WIDTH = 5,
  parameter logic [31:0] ID_VALUE  = ID_VALUE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic [3:0]           offset_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  output logic [LED_WIDTH-1:0] led_o
);

  logic [LED_WIDTH-1:0] led_q;
  logic [31:0]          timer_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
    end else if (we_i && offset_i == IO_LED) begin
      led_q <= wdata_i[LED_WIDTH-1:0];
    end
  end

`ifdef ZPU_BRIDGE_TIMER_EN
  logic [31:0] timer_q;

  // A load takes the place of that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (we_i && offset_i == IO_TIMER) begin
      timer_q <= wdata_i;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign timer_val = timer_q;
`else
  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata_i[31:LED_WIDTH]};
  assign timer_val    = '0;
`endif

  always_comb begin
    rdata_o = '0;
    case (offset_i)
      IO_LED:   rdata_o = 32'(led_q);
      IO_ID:    rdata_o = ID_VALUE;
      IO_TIMER: rdata_o = timer_val;
      default:  rdata_o = '0;
    endcase
  end

  assign led_o = led_q;

endmodule

// File: rtl/zpu_mem_bridge.sv
// Memory bridge between zpu_core and internal_ram/I-O page. ram_dout is
// sampled on the RAM_LATENCY-th clock edge after ram_addr is registered.
// Optional timer register: define ZPU_BRIDGE_TIMER_EN.
module zpu_mem_bridge
  import zpu_bridge_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          RAM_AW      = 10,
  parameter int          RAM_LATENCY = 1,
  parameter int          LED_WIDTH   = 5,
  parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  zpu_mem_bridge_if.slave      bus,
  output logic [LED_WIDTH-1:0] led
);

  localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

  state_e            state_q, state_d;
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [31:0]       ram_din_q, ram_din_d;

  logic        req;
  logic        is_io;
  logic        io_we;
  logic [31:0] io_rdata;
  logic        unused_addr;

  assign req         = bus.cpu_read | bus.cpu_write;
  assign is_io       = bus.cpu_addr[ADDR_WIDTH-1];
  assign unused_addr = &{1'b0, bus.cpu_addr[1:0]};

  zpu_bridge_io #(
    .LED_WIDTH (LED_WIDTH),
    .ID_VALUE  (ID_VALUE)
  ) u_io (
    .clk      (clk),
    .reset    (reset),
    .we_i     (io_we),
    .offset_i (bus.cpu_addr[5:2]),
    .wdata_i  (bus.cpu_wdata),
    .rdata_o  (io_rdata),
    .led_o    (led)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    done_d     = 1'b0;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    ram_we_d   = 1'b0;
    ram_din_d  = ram_din_q;
    io_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (is_io) begin
            state_d = IO;
            done_d  = 1'b1;
            if (bus.cpu_write) io_we   = 1'b1;
            else               rdata_d = io_rdata;
          end else begin
            ram_addr_d = bus.cpu_addr[RAM_AW+1:2];
            // Write wins when read and write are both requested.
            if (bus.cpu_write) begin
              state_d   = RAM_WR;
              ram_we_d  = 1'b1;
              ram_din_d = bus.cpu_wdata;
              done_d    = 1'b1;
            end else begin
              state_d   = RAM_RD;
              lat_cnt_d = LAT_LAST;
            end
          end
        end
      end
      RAM_RD: begin
        if (lat_cnt_q == 2'd0) begin
          state_d = DONE;
          done_d  = 1'b1;
          rdata_d = bus.ram_dout;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      RAM_WR,
      IO:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_din_q  <= ram_din_d;
    end
  end

  assign bus.cpu_done  = done_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_din   = ram_din_q;

endmodule

// File: tb/tb_zpu_mem_bridge.sv
// Directed bench for zpu_mem_bridge: two instances (RAM_LATENCY 1 and 3) see
// identical stimulus, each backed by its own RAM model of matching latency.
module tb_zpu_mem_bridge;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  zpu_mem_bridge_if #(.ADDR_WIDTH(12), .RAM_AW(10)) b1 ();
  zpu_mem_bridge_if #(.ADDR_WIDTH(12), .RAM_AW(10)) b3 ();
  logic [4:0] led1, led3;

  zpu_mem_bridge #(.RAM_LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave),
    .led   (led1)
  );

  zpu_mem_bridge #(.RAM_LATENCY(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3.slave),
    .led   (led3)
  );

  // Latency 1: asynchronous read of the registered address.
  logic [31:0] mem1 [0:1023];
  always @(posedge clk) if (b1.ram_we) mem1[b1.ram_addr] <= b1.ram_din;
  assign b1.ram_dout = mem1[b1.ram_addr];

  // Latency 3: two pipeline stages after the array read.
  logic [31:0] mem3 [0:1023];
  logic [31:0] pipe1, pipe2;
  always @(posedge clk) begin
    if (b3.ram_we) mem3[b3.ram_addr] <= b3.ram_din;
    pipe1 <= mem3[b3.ram_addr];
    pipe2 <= pipe1;
  end
  assign b3.ram_dout = pipe2;

  int checks = 0;
  int errors = 0;
  int done1_cnt = 0;
  int done3_cnt = 0;
  int we3_cnt = 0;
  int d1, d3, w3;

  always @(negedge clk) begin
    if (b1.cpu_done) done1_cnt++;
    if (b3.cpu_done) done3_cnt++;
    if (b3.ram_we)   we3_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input bit rd, input bit wr, input logic [11:0] a, input logic [31:0] d);
    b1.cpu_read  = rd; b1.cpu_write = wr; b1.cpu_addr = a; b1.cpu_wdata = d;
    b3.cpu_read  = rd; b3.cpu_write = wr; b3.cpu_addr = a; b3.cpu_wdata = d;
  endtask

  // Drive a one-cycle request; returns at the negedge of request+1.
  task automatic pulse(input bit rd, input bit wr, input logic [11:0] a, input logic [31:0] d);
    set_req(rd, wr, a, d);
    @(negedge clk);
    set_req(1'b0, 1'b0, 12'h000, 32'h0);
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    set_req(1'b0, 1'b0, 12'h000, 32'h0);
    ticks(2);
    check("rst_done",     b1.cpu_done,  32'h0);
    check("rst_rdata",    b1.cpu_rdata, 32'h0);
    check("rst_ram_addr", b1.ram_addr,  32'h0);
    check("rst_ram_we",   b1.ram_we,    32'h0);
    check("rst_ram_din",  b1.ram_din,   32'h0);
    check("rst_led",      led1,         32'h0);
    reset = 1'b0;
    ticks(1);

    // RAM write: strobe, address and done all at request+1
    pulse(1'b0, 1'b1, 12'h010, 32'hDEAD_BEEF);
    check("wr_we",    b1.ram_we,   32'h1);
    check("wr_addr",  b1.ram_addr, 32'h4);
    check("wr_din",   b1.ram_din,  32'hDEAD_BEEF);
    check("wr_done",  b1.cpu_done, 32'h1);
    check("wr_done3", b3.cpu_done, 32'h1);
    ticks(1);
    check("wr_we_off",   b1.ram_we,   32'h0);
    check("wr_done_off", b1.cpu_done, 32'h0);
    ticks(1);
    pulse(1'b0, 1'b1, 12'h024, 32'h1234_5678);
    ticks(2);

    // RAM read: latency 1 done at request+2, latency 3 at request+4
    pulse(1'b1, 1'b0, 12'h010, 32'h0);
    check("rd1_early", b1.cpu_done, 32'h0);
    ticks(1);
    check("rd1_done",  b1.cpu_done,  32'h1);
    check("rd1_data",  b1.cpu_rdata, 32'hDEAD_BEEF);
    check("rd3_early", b3.cpu_done,  32'h0);
    ticks(1);
    check("rd1_pulse_end", b1.cpu_done,  32'h0);
    check("rd1_hold",      b1.cpu_rdata, 32'hDEAD_BEEF);
    check("rd3_early2",    b3.cpu_done,  32'h0);
    ticks(1);
    check("rd3_done", b3.cpu_done,  32'h1);
    check("rd3_data", b3.cpu_rdata, 32'hDEAD_BEEF);
    ticks(1);

    // Second read pulse while busy must be dropped
    d1 = done1_cnt; d3 = done3_cnt;
    pulse(1'b1, 1'b0, 12'h024, 32'h0);
    pulse(1'b1, 1'b0, 12'h010, 32'h0);
    ticks(3);
    check("busy_done1", done1_cnt - d1, 32'h1);
    check("busy_done3", done3_cnt - d3, 32'h1);
    check("busy_data1", b1.cpu_rdata,   32'h1234_5678);
    check("busy_data3", b3.cpu_rdata,   32'h1234_5678);

    // Read and write together is a write; writes leave cpu_rdata alone
    pulse(1'b1, 1'b1, 12'h030, 32'hCAFE_F00D);
    check("both_we",         b1.ram_we,   32'h1);
    check("both_done",       b1.cpu_done, 32'h1);
    check("wr_keeps_rdata",  b1.cpu_rdata, 32'h1234_5678);
    ticks(2);
    pulse(1'b1, 1'b0, 12'h030, 32'h0);
    ticks(3);
    check("both_rd3", b3.cpu_rdata, 32'hCAFE_F00D);
    ticks(1);

    // I/O page
    pulse(1'b0, 1'b1, 12'h800, 32'h0000_001F);
    check("led_wr",      led1,        32'h1F);
    check("led_wr_done", b1.cpu_done, 32'h1);
    ticks(2);
    pulse(1'b1, 1'b0, 12'h800, 32'h0);
    check("led_rd",      b1.cpu_rdata, 32'h0000_001F);
    check("led_rd_done", b1.cpu_done,  32'h1);
    ticks(2);
    pulse(1'b1, 1'b0, 12'h804, 32'h0);
    check("id_rd", b1.cpu_rdata, 32'h5A50_0001);
    ticks(2);
    pulse(1'b0, 1'b1, 12'h804, 32'h0);
    check("id_wr_done",  b1.cpu_done,  32'h1);
    check("id_wr_rdata", b1.cpu_rdata, 32'h5A50_0001);
    ticks(2);
    pulse(1'b1, 1'b0, 12'h804, 32'h0);
    check("id_rd2", b1.cpu_rdata, 32'h5A50_0001);
    ticks(2);
    pulse(1'b0, 1'b1, 12'h800, 32'hFFFF_FFE3);
    check("led_trunc", led1, 32'h03);
    ticks(2);
    pulse(1'b0, 1'b1, 12'h83C, 32'hFFFF_FFFF);
    check("oth_wr_done", b1.cpu_done, 32'h1);
    check("oth_wr_led",  led1,        32'h03);
    ticks(2);
    pulse(1'b1, 1'b0, 12'h83C, 32'h0);
    check("oth_rd", b1.cpu_rdata, 32'h0);
    ticks(2);

`ifdef ZPU_BRIDGE_TIMER_EN
    // Load at edge W: W+1 FFFFFFFE, W+2 FFFFFFFF, W+3 0, W+4 1, W+5 2
    pulse(1'b0, 1'b1, 12'h808, 32'hFFFF_FFFE);
    ticks(4);
    pulse(1'b1, 1'b0, 12'h808, 32'h0);
    check("timer_wrap", b1.cpu_rdata, 32'h0000_0002);
`else
    pulse(1'b1, 1'b0, 12'h804, 32'h0);
    ticks(2);
    pulse(1'b1, 1'b0, 12'h808, 32'h0);
    check("timer_off", b1.cpu_rdata, 32'h0);
`endif
    ticks(2);

    // Reset in the middle of a latency-3 read
    pulse(1'b1, 1'b0, 12'h024, 32'h0);
    check("pre_rst_addr3", b3.ram_addr, 32'h9);
    d3 = done3_cnt; w3 = we3_cnt;
    reset = 1'b1;
    #1;
    check("rst_mid_done3",  b3.cpu_done,  32'h0);
    check("rst_mid_addr3",  b3.ram_addr,  32'h0);
    check("rst_mid_din3",   b3.ram_din,   32'h0);
    check("rst_mid_rdata3", b3.cpu_rdata, 32'h0);
    check("rst_mid_led3",   led3,         32'h0);
    @(negedge clk);
    reset = 1'b0;
    ticks(6);
    check("rst_no_done3", done3_cnt - d3, 32'h0);
    check("rst_no_we3",   we3_cnt - w3,   32'h0);
    pulse(1'b1, 1'b0, 12'h024, 32'h0);
    ticks(3);
    check("post_rst_done3", b3.cpu_done,  32'h1);
    check("post_rst_data3", b3.cpu_rdata, 32'h1234_5678);
    ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
